// File: rtl/ps2_rx.sv
// ps2_rx: host-side PS/2 receiver.
// It samples frames that a PS/2 device clocks onto PS2_CLK/PS2_DATA. Each
// frame is start(0), 8 data bits LSB first, odd parity, then stop(1). Every
// byte that passes all checks is delivered with a one-cycle rd_valid strobe.
// The block only samples the two lines and never drives either of them.
//
// Ports:
//   clk_sys     - system clock
//   rst_n       - asynchronous active-low reset
//   PS2_CLK     - PS/2 clock line (sampled only)
//   PS2_DATA    - PS/2 data line (sampled only)
//   rx_en       - receive enable; low forces IDLE and drops any partial frame
//   rd_valid    - one-cycle strobe: rd_data holds a new valid byte
//   rd_data     - last good byte received; held between frames and on errors
//   err_parity  - one-cycle strobe: parity check failed
//   err_frame   - one-cycle strobe: bad start bit or bad stop bit
//   err_timeout - one-cycle strobe: frame stalled between clock edges
//   busy        - high while a frame is in progress (state != IDLE)
module ps2_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk_sys,
  input  logic       rst_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  input  logic       rx_en,
  output logic       rd_valid,
  output logic [7:0] rd_data,
  output logic       err_parity,
  output logic       err_frame,
  output logic       err_timeout,
  output logic       busy
);

  localparam int FCW = $clog2(FILTER_LEN) + 1;
  localparam int TCW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [FCW-1:0] FILT_MAX = FCW'(FILTER_LEN - 1);
  localparam logic [TCW-1:0] TMO_MAX  = TCW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Odd parity holds when the data byte plus its parity bit carry an odd
  // number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Input conditioning
  logic           clk_meta_r, clk_sync_r;
  logic           data_meta_r, data_sync_r;
  logic [FCW-1:0] filt_cnt_r;
  logic           clk_filt_r, clk_filt_prev_r;
  logic           fall_s;

  // Receiver state
  state_t         state_r, state_s;
  logic [2:0]     bit_cnt_r, bit_cnt_s;
  logic [7:0]     shift_r, shift_s;
  logic           parity_r, parity_s;
  logic [TCW-1:0] tmo_cnt_r, tmo_cnt_s;
  logic [7:0]     rd_data_r, rd_data_s;
  logic           rd_valid_r, rd_valid_s;
  logic           err_parity_r, err_parity_s;
  logic           err_frame_r, err_frame_s;
  logic           err_timeout_r, err_timeout_s;
  logic           busy_r;

  // Two-flop synchronizers for both PS/2 lines; idle bus level is high.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= PS2_CLK;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= PS2_DATA;
      data_sync_r <= data_meta_r;
    end
  end

  // Glitch filter: the filtered clock follows the synchronized clock only
  // after it has held a new level for FILTER_LEN consecutive cycles.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      filt_cnt_r      <= {FCW{1'b0}};
      clk_filt_r      <= 1'b1;
      clk_filt_prev_r <= 1'b1;
    end else begin
      clk_filt_prev_r <= clk_filt_r;
      if (clk_sync_r != clk_filt_r) begin
        if (filt_cnt_r == FILT_MAX) begin
          clk_filt_r <= clk_sync_r;
          filt_cnt_r <= {FCW{1'b0}};
        end else begin
          filt_cnt_r <= filt_cnt_r + FCW'(1);
        end
      end else begin
        filt_cnt_r <= {FCW{1'b0}};
      end
    end
  end

  assign fall_s = clk_filt_prev_r & ~clk_filt_r;

  // Next-state and strobe logic. rx_en dominates, then the stall timeout,
  // then any falling edge of the filtered clock.
  always_comb begin
    state_s       = state_r;
    bit_cnt_s     = bit_cnt_r;
    shift_s       = shift_r;
    parity_s      = parity_r;
    tmo_cnt_s     = tmo_cnt_r;
    rd_data_s     = rd_data_r;
    rd_valid_s    = 1'b0;
    err_parity_s  = 1'b0;
    err_frame_s   = 1'b0;
    err_timeout_s = 1'b0;

    if (!rx_en) begin
      state_s   = ST_IDLE;
      bit_cnt_s = 3'd0;
      tmo_cnt_s = {TCW{1'b0}};
    end else if ((state_r != ST_IDLE) && (tmo_cnt_r == TMO_MAX)) begin
      // Stalled frame: drop whatever was collected.
      err_timeout_s = 1'b1;
      state_s       = ST_IDLE;
      bit_cnt_s     = 3'd0;
      shift_s       = 8'h00;
      tmo_cnt_s     = {TCW{1'b0}};
    end else begin
      if (state_r == ST_IDLE) begin
        tmo_cnt_s = {TCW{1'b0}};
      end else if (fall_s) begin
        tmo_cnt_s = {TCW{1'b0}};
      end else begin
        tmo_cnt_s = tmo_cnt_r + TCW'(1);
      end

      if (fall_s) begin
        case (state_r)
          ST_IDLE: begin
            if (!data_sync_r) begin
              state_s   = ST_DATA;
              bit_cnt_s = 3'd0;
            end else begin
              err_frame_s = 1'b1;
            end
          end
          ST_DATA: begin
            // LSB arrives first, so shift right and insert at the top.
            shift_s   = {data_sync_r, shift_r[7:1]};
            bit_cnt_s = bit_cnt_r + 3'd1;
            if (bit_cnt_r == 3'd7) begin
              state_s = ST_PARITY;
            end else begin
              state_s = ST_DATA;
            end
          end
          ST_PARITY: begin
            parity_s = data_sync_r;
            state_s  = ST_STOP;
          end
          ST_STOP: begin
            state_s = ST_IDLE;
            // A bad stop bit outranks a parity error.
            if (!data_sync_r) begin
              err_frame_s = 1'b1;
            end else if (odd_parity_ok(shift_r, parity_r)) begin
              rd_data_s  = shift_r;
              rd_valid_s = 1'b1;
            end else begin
              err_parity_s = 1'b1;
            end
          end
          default: begin
            state_s = ST_IDLE;
          end
        endcase
      end else begin
        state_s = state_r;
      end
    end
  end

  // Receiver state and registered outputs.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= 3'd0;
      shift_r       <= 8'h00;
      parity_r      <= 1'b0;
      tmo_cnt_r     <= {TCW{1'b0}};
      rd_data_r     <= 8'h00;
      rd_valid_r    <= 1'b0;
      err_parity_r  <= 1'b0;
      err_frame_r   <= 1'b0;
      err_timeout_r <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      bit_cnt_r     <= bit_cnt_s;
      shift_r       <= shift_s;
      parity_r      <= parity_s;
      tmo_cnt_r     <= tmo_cnt_s;
      rd_data_r     <= rd_data_s;
      rd_valid_r    <= rd_valid_s;
      err_parity_r  <= err_parity_s;
      err_frame_r   <= err_frame_s;
      err_timeout_r <= err_timeout_s;
      busy_r        <= (state_s != ST_IDLE);
    end
  end

  assign rd_valid    = rd_valid_r;
  assign rd_data     = rd_data_r;
  assign err_parity  = err_parity_r;
  assign err_frame   = err_frame_r;
  assign err_timeout = err_timeout_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_ps2_rx.sv
// Directed testbench for ps2_rx. Uses a short PS/2 half-period and a small
// timeout so the whole run stays short. Strobes are counted by a monitor at
// the falling clock edge; the stimulus sequence compares count deltas,
// rd_data, busy and latencies against hand-computed values.
module tb_ps2_rx;

  localparam int FILT = 8;
  localparam int TMO  = 200;
  localparam int HALF = 40;
  // Line fall -> rd_valid/err edge: 2 sync flops + FILT filter cycles + 1.
  localparam int LAT  = FILT + 3;

  logic       clk_sys = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rx_en = 1'b1;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       err_parity, err_frame, err_timeout, busy;

  int n_checks = 0;
  int n_err = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0, n_tmo = 0, n_multi = 0;
  int s_valid, s_perr, s_ferr, s_tmo;
  int lat;

  ps2_rx #(.FILTER_LEN(FILT), .TIMEOUT_CYC(TMO)) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .PS2_CLK     (ps2_clk),
    .PS2_DATA    (ps2_data),
    .rx_en       (rx_en),
    .rd_valid    (rd_valid),
    .rd_data     (rd_data),
    .err_parity  (err_parity),
    .err_frame   (err_frame),
    .err_timeout (err_timeout),
    .busy        (busy)
  );

  always #5 clk_sys = ~clk_sys;

  // Strobe monitor
  always @(negedge clk_sys) begin
    if (rd_valid)    n_valid <= n_valid + 1;
    if (err_parity)  n_perr  <= n_perr + 1;
    if (err_frame)   n_ferr  <= n_ferr + 1;
    if (err_timeout) n_tmo   <= n_tmo + 1;
    if ((32'(rd_valid) + 32'(err_parity) + 32'(err_frame) + 32'(err_timeout)) > 32'd1)
      n_multi <= n_multi + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic snap();
    s_valid = n_valid; s_perr = n_perr; s_ferr = n_ferr; s_tmo = n_tmo;
  endtask

  task automatic bit_out(input logic b);
    ps2_data = b;
    cyc(HALF);
    ps2_clk = 1'b0;
    cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  // Start bit plus the first nbits data bits.
  task automatic frame_head(input logic [7:0] d, input int nbits);
    bit_out(1'b0);
    for (int i = 0; i < nbits; i++) bit_out(d[i]);
  endtask

  // Data bits from..7, parity, then a stop bit whose fall is timed: lat is
  // the number of clk_sys edges from the line fall to the first strobe.
  task automatic send_tail(input logic [7:0] d, input int from, input logic par,
                           input logic stp, output int l);
    for (int i = from; i < 8; i++) bit_out(d[i]);
    bit_out(par);
    ps2_data = stp;
    cyc(HALF);
    ps2_clk = 1'b0;
    l = -1;
    for (int n = 1; n <= 2 * HALF; n++) begin
      @(posedge clk_sys);
      #1;
      if (l < 0 && (rd_valid || err_parity || err_frame || err_timeout)) l = n;
      if (n == HALF) ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                            output int l);
    bit_out(1'b0);
    send_tail(d, 0, par, stp, l);
  endtask

  initial begin
    int tl;
    // Reset state
    cyc(3);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    chk("rst_data", 32'(rd_data), 32'h00);
    chk("rst_errs", 32'({err_parity, err_frame, err_timeout}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    cyc(5);

    // Good byte 0x1C (three ones -> parity 0)
    snap();
    send_frame(8'h1C, 1'b0, 1'b1, lat);
    chk("1c_lat", 32'(lat), 32'(LAT));
    chk("1c_valid", 32'(n_valid - s_valid), 32'd1);
    chk("1c_data", 32'(rd_data), 32'h1C);
    chk("1c_errs", 32'((n_perr - s_perr) + (n_ferr - s_ferr) + (n_tmo - s_tmo)), 32'd0);
    chk("1c_busy", 32'(busy), 32'd0);

    // 0xF0 with wrong parity (correct would be 1)
    snap();
    send_frame(8'hF0, 1'b0, 1'b1, lat);
    chk("f0_lat", 32'(lat), 32'(LAT));
    chk("f0_perr", 32'(n_perr - s_perr), 32'd1);
    chk("f0_valid", 32'(n_valid - s_valid), 32'd0);
    chk("f0_ferr", 32'(n_ferr - s_ferr), 32'd0);
    chk("f0_data", 32'(rd_data), 32'h1C);

    // 0x55 with correct parity 1 but stop=0
    snap();
    send_frame(8'h55, 1'b1, 1'b0, lat);
    chk("55_ferr", 32'(n_ferr - s_ferr), 32'd1);
    chk("55_perr", 32'(n_perr - s_perr), 32'd0);
    chk("55_valid", 32'(n_valid - s_valid), 32'd0);
    chk("55_data", 32'(rd_data), 32'h1C);

    // Stray fall with data=1 while idle
    snap();
    bit_out(1'b1);
    cyc(20);
    chk("stray_ferr", 32'(n_ferr - s_ferr), 32'd1);
    chk("stray_busy", 32'(busy), 32'd0);

    // Timeout: start + 4 data bits (0x0D -> 1,0,1,1), then clock held high
    snap();
    frame_head(8'h0D, 3);
    chk("tmo_busy_mid", 32'(busy), 32'd1);
    ps2_data = 1'b1;
    cyc(HALF);
    ps2_clk = 1'b0;
    tl = -1;
    for (int n = 1; n <= TMO + LAT + 50; n++) begin
      @(posedge clk_sys);
      #1;
      if (tl < 0 && err_timeout) tl = n;
      if (n == HALF) ps2_clk = 1'b1;
    end
    chk("tmo_lat", 32'(tl), 32'(TMO + LAT));
    chk("tmo_count", 32'(n_tmo - s_tmo), 32'd1);
    chk("tmo_valid", 32'(n_valid - s_valid), 32'd0);
    chk("tmo_busy", 32'(busy), 32'd0);

    // 0x12 (two ones -> parity 1) after the timeout
    snap();
    send_frame(8'h12, 1'b1, 1'b1, lat);
    chk("12_valid", 32'(n_valid - s_valid), 32'd1);
    chk("12_data", 32'(rd_data), 32'h12);

    // 5-cycle glitch while idle
    snap();
    ps2_clk = 1'b0;
    cyc(5);
    ps2_clk = 1'b1;
    cyc(30);
    chk("gidle_busy", 32'(busy), 32'd0);
    chk("gidle_strobes", 32'((n_valid - s_valid) + (n_perr - s_perr) + (n_ferr - s_ferr)), 32'd0);

    // 5-cycle glitch inside DATA, frame 0x3C (four ones -> parity 1)
    snap();
    frame_head(8'h3C, 2);
    ps2_clk = 1'b0;
    cyc(5);
    ps2_clk = 1'b1;
    cyc(HALF);
    chk("gdata_busy", 32'(busy), 32'd1);
    send_tail(8'h3C, 2, 1'b1, 1'b1, lat);
    chk("3c_lat", 32'(lat), 32'(LAT));
    chk("3c_valid", 32'(n_valid - s_valid), 32'd1);
    chk("3c_data", 32'(rd_data), 32'h3C);
    chk("3c_errs", 32'((n_perr - s_perr) + (n_ferr - s_ferr) + (n_tmo - s_tmo)), 32'd0);

    // rx_en drop mid-frame, then 0xAA (four ones -> parity 1)
    snap();
    frame_head(8'h0F, 3);
    chk("en_busy_mid", 32'(busy), 32'd1);
    rx_en = 1'b0;
    cyc(5);
    chk("en_busy_off", 32'(busy), 32'd0);
    cyc(HALF);
    rx_en = 1'b1;
    cyc(HALF);
    send_frame(8'hAA, 1'b1, 1'b1, lat);
    chk("aa_valid", 32'(n_valid - s_valid), 32'd1);
    chk("aa_errs", 32'((n_perr - s_perr) + (n_ferr - s_ferr) + (n_tmo - s_tmo)), 32'd0);
    chk("aa_data", 32'(rd_data), 32'hAA);

    // Asynchronous reset mid-frame
    snap();
    frame_head(8'h33, 3);
    chk("rs_busy_mid", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_data", 32'(rd_data), 32'h00);
    chk("rs_valid", 32'(rd_valid), 32'd0);
    chk("rs_errs", 32'({err_parity, err_frame, err_timeout}), 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(5);

    // 0x07 (three ones -> parity 0) after reset
    snap();
    send_frame(8'h07, 1'b0, 1'b1, lat);
    chk("07_valid", 32'(n_valid - s_valid), 32'd1);
    chk("07_data", 32'(rd_data), 32'h07);
    chk("07_errs", 32'((n_perr - s_perr) + (n_ferr - s_ferr) + (n_tmo - s_tmo)), 32'd0);

    chk("no_overlap", 32'(n_multi), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
Host-side PS/2 receiver. It samples frames that a PS/2 device (keyboard or mouse) clocks onto PS2_CLK/PS2_DATA and delivers each valid byte to the core logic as a one-cycle strobe. It checks the start, parity and stop bits, and flags frames that stall partway through. It sits beside the host PS/2 transmitter on the same two lines. It never drives either line; rx_en lets the controller mute it while the transmitter owns the bus.

Parameters:
FILTER_LEN, 8, consecutive clk_sys cycles the synchronized PS2_CLK must hold a new level before the filtered clock changes.
TIMEOUT_CYC, 100000, maximum clk_sys cycles between falling edges inside a frame (2 ms at 50 MHz).

Ports:
clk_sys  input  1  50 MHz system clock
rst_n  input  1  asynchronous active-low reset
PS2_CLK  input  1  PS/2 clock line, sampled only
PS2_DATA  input  1  PS/2 data line, sampled only
rx_en  input  1  receive enable; low forces IDLE
rd_valid  output  1  one-cycle strobe: rd_data holds a new valid byte
rd_data  output  8  last good byte received; held between frames
err_parity  output  1  one-cycle strobe: parity check failed
err_frame  output  1  one-cycle strobe: bad start or stop bit
err_timeout  output  1  one-cycle strobe: frame stalled
busy  output  1  high while in any state other than IDLE

Behaviour:
- Reset is asynchronous, rst_n active-low, clock clk_sys. Reset values: rd_valid=0, rd_data=8'h00, err_*=0, busy=0, FSM=IDLE, counters=0, synchronizers=1, filtered clock=1.
- Input conditioning:
  - PS2_CLK and PS2_DATA each pass through a 2-flop synchronizer.
  - Filter counter: counts while the synchronized clock differs from the filtered clock; clears when they match.
  - The filtered clock takes the new level when the count reaches FILTER_LEN-1.
  - A falling edge (fall) is filtered previous=1 and current=0. It is valid for exactly one cycle.
  - On fall, the synchronized data is sampled.
- Frame format: start=0, 8 data bits LSB first, odd parity, stop=1. Every bit is sampled on fall.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on fall with data=0, go to DATA, clear bit_cnt, clear the timeout counter. On fall with data=1, pulse err_frame and stay in IDLE.
  - DATA: on fall, shift the bit into shift_reg[7] (right shift) and increment bit_cnt. On fall with bit_cnt=7, go to PARITY.
  - PARITY: on fall, store the parity bit and go to STOP.
  - STOP: on fall, go to IDLE and check the frame:
    - stop=1 and ^{shift_reg,parity}=1: rd_data<=shift_reg, pulse rd_valid.
    - stop=0: pulse err_frame. err_frame takes priority over a parity error.
    - otherwise (stop=1, parity bad): pulse err_parity.
    - rd_data is unchanged on any error.
- Latency: rd_valid, err_parity and err_frame are asserted in the cycle after the stop-bit fall is detected. Exactly one of them is asserted per completed frame.
- Timeout:
  - Outside IDLE, a counter increments every cycle and clears on each fall.
  - At TIMEOUT_CYC-1: pulse err_timeout, go to IDLE, discard partial data. This check has priority over a fall in the same cycle.
- rx_en=0: FSM forced to IDLE, counters cleared, no strobes. rd_data is held. The synchronizers and filter keep running so edge state stays current. A frame in progress when rx_en drops is lost silently. After rx_en returns to 1, the next fall with data=0 starts a new frame.
- Strobes are single-cycle and never asserted together.
- busy = (state != IDLE).

Test Plan:
- Send 0x1C (parity 0, stop 1) with a 40 µs half-period (2000 cycles) -> one rd_valid pulse, rd_data=0x1C, no err_*, busy low after the stop bit.
- Send 0xF0 with parity 0 (wrong) -> err_parity pulse, rd_valid stays 0, rd_data keeps the previous 0x1C.
- Send 0x55 with stop=0 -> err_frame only. Then a fall with data=1 in IDLE -> err_frame, FSM stays in IDLE.
- Send start plus 4 data bits, then hold PS2_CLK high -> err_timeout exactly TIMEOUT_CYC cycles after the last fall. A following 0x12 frame is received correctly.
- 5-cycle low glitch on PS2_CLK (shorter than FILTER_LEN) in IDLE and in DATA -> no state change, no bit counted. The frame that follows decodes correctly.
- Drop rx_en at bit 3, raise it, then send 0xAA -> no strobe from the aborted frame, rd_valid with 0xAA. Repeat the mid-frame abort with rst_n instead -> all outputs return to reset values immediately.
